// File: rtl/zueirai_pkg.sv
// Shared definitions for the ZueiraI issue stage: ALU control codes,
// flag bit positions and default sizing.
package zueirai_pkg;

   typedef enum logic [2:0] {
      NOP = 3'd0,
      ADD = 3'd1,
      SUB = 3'd2,
      AND = 3'd3,
      OR  = 3'd4,
      NOT = 3'd5,
      SHL = 3'd6,
      SHR = 3'd7
   } alu_ctrl_e;

   localparam int FLAG_O = 2;
   localparam int FLAG_U = 1;
   localparam int FLAG_Z = 0;

   localparam int DATA_W_DEF = 8;
   localparam int NREGS_DEF  = 8;

endpackage

// File: rtl/zueirai_scoreboard.sv
// Per-register busy scoreboard. Tracks registers with a pending write,
// arbitrates same-cycle set/clear (set wins) and flags issue hazards.
// The bypass inputs mask hazards on the register being written back this
// cycle; the top ties byp_en low when forwarding is not built in.
module zueirai_scoreboard
   import zueirai_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dest,
   input  logic              dest_we,
   input  logic              byp_en,
   input  logic [ADDR_W-1:0] byp_addr,
   output logic              hazard
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             haz_a;
   logic             haz_b;
   logic             haz_d;

   // Clear first, then set, so a same-cycle set on the same register wins.
   // r0 is never marked busy since writes to it are discarded.
   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[clr_addr] = 1'b0;
      if (set_en && (set_addr != '0)) busy_nxt[set_addr] = 1'b1;
   end

   // Busy vector register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // Hazard detection: RAW on either source, WAW on the destination.
   always_comb begin
      haz_a  = (src_a != '0) && busy[src_a] && !(byp_en && (byp_addr == src_a));
      haz_b  = (src_b != '0) && busy[src_b] && !(byp_en && (byp_addr == src_b));
      haz_d  = dest_we && busy[dest] && !(byp_en && (byp_addr == dest));
      hazard = haz_a || haz_b || haz_d;
   end

endmodule

// File: rtl/zueirai_issue_stage.sv
// Operand-issue stage for the ZueiraI ALU: register file, busy scoreboard
// and a registered valid/ready operand interface toward the ALU.
// Optional macro ZUEIRAI_WB_BYPASS_EN forwards same-cycle writeback data
// to the source reads and masks the matching scoreboard hazards.
module zueirai_issue_stage
   import zueirai_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        issue_ctrl,
   input  logic [ADDR_W-1:0] issue_src_a,
   input  logic [ADDR_W-1:0] issue_src_b,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic              issue_we,
   output logic              alu_valid,
   input  logic              alu_ready,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_ctrl,
   output logic [ADDR_W-1:0] alu_dest,
   output logic              alu_we,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [2:0]        wb_flags,
   output logic [2:0]        flags_q
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              hazard;
   logic              accept;
   logic              byp_en;

`ifdef ZUEIRAI_WB_BYPASS_EN
   assign byp_en = wb_en;
`else
   assign byp_en = 1'b0;
`endif

   assign issue_ready = (!alu_valid || alu_ready) && !hazard;
   assign accept      = issue_valid && issue_ready;

   zueirai_scoreboard #(
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (accept && issue_we),
      .set_addr (issue_dest),
      .clr_en   (wb_en),
      .clr_addr (wb_addr),
      .src_a    (issue_src_a),
      .src_b    (issue_src_b),
      .dest     (issue_dest),
      .dest_we  (issue_we),
      .byp_en   (byp_en),
      .byp_addr (wb_addr),
      .hazard   (hazard)
   );

   // Source reads: r0 is hardwired to zero, optional writeback forwarding.
   always_comb begin
      rd_a = regs[issue_src_a];
      rd_b = regs[issue_src_b];
      if (byp_en && (wb_addr == issue_src_a)) rd_a = wb_data;
      if (byp_en && (wb_addr == issue_src_b)) rd_b = wb_data;
      if (issue_src_a == '0) rd_a = '0;
      if (issue_src_b == '0) rd_b = '0;
   end

   // Register file writeback; writes to r0 are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Flag register follows every writeback, including ones to r0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        flags_q <= '0;
      else if (wb_en) flags_q <= wb_flags;
   end

   // ALU-facing output register: load on accept, drop valid once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_valid <= 1'b0;
         alu_in1   <= '0;
         alu_in2   <= '0;
         alu_ctrl  <= 3'(NOP);
         alu_dest  <= '0;
         alu_we    <= 1'b0;
      end else if (accept) begin
         alu_valid <= 1'b1;
         alu_in1   <= rd_a;
         alu_in2   <= rd_b;
         alu_ctrl  <= issue_ctrl;
         alu_dest  <= issue_dest;
         alu_we    <= issue_we;
      end else if (alu_ready) begin
         alu_valid <= 1'b0;
      end
   end

endmodule
